fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// One request may be granted at a time; each grant is answered by a single rvalid beat.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory request, a small prefetch FIFO feeding
// decode, and redirect handling that flushes queued work and discards in-flight data.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master imem,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         inst_valid,
    output logic [31:0]  inst_data,
    output logic [31:0]  inst_pc,
    input  logic         inst_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_addr_q, req_addr_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic [31:0]      ipc_q  [DEPTH];
    logic [31:0]      ipc_d  [DEPTH];

    logic             req;
    logic             grant;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] level;
    logic [31:0]      target_pc;

    assign target_pc = redirect_pc & 32'hFFFF_FFFC;
    assign pop       = valid_q & inst_ready;
    assign level     = count_q - CNT_W'(pop);

    // run_q holds requests off until the first clock edge after reset is released.
    assign run_d = 1'b1;
    assign req   = (state_q == ST_REQ) && run_q && (level < CNT_W'(DEPTH));
    assign grant = req & imem.imem_gnt;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        unique case (state_q)
            ST_REQ: begin
                if (grant) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = redirect ? ST_DROP : ST_WAIT;
                end
                if (redirect) begin
                    pc_d = target_pc;
                end
            end
            ST_WAIT: begin
                if (imem.imem_rvalid) begin
                    state_d = ST_REQ;
                    push    = !redirect && (level < CNT_W'(DEPTH));
                end else if (redirect) begin
                    state_d = ST_DROP;
                end
                if (redirect) begin
                    pc_d = target_pc;
                end
            end
            ST_DROP: begin
                if (imem.imem_rvalid) begin
                    state_d = ST_REQ;
                end
                if (redirect) begin
                    pc_d = target_pc;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    // Shift-register FIFO: entry 0 is always the head, so decode outputs come straight from flops.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
            ipc_d[i]  = ipc_q[i];
        end
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                data_d[i] = data_q[i + 1];
                ipc_d[i]  = ipc_q[i + 1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == level) begin
                    data_d[i] = imem.imem_rdata;
                    ipc_d[i]  = req_addr_q;
                end
            end
        end
        count_d = level + CNT_W'(push);
        if (redirect) begin
            count_d = '0;
        end
    end

    assign valid_d = (count_d != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            run_q      <= 1'b0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                ipc_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            run_q      <= run_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
                ipc_q[i]  <= ipc_d[i];
            end
        end
    end

    assign inst_valid = valid_q;
    assign inst_data  = data_q[0];
    assign inst_pc    = ipc_q[0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a memory model answers grants after a random latency, and an
// in-order address-stream model predicts every fetch address and every decoded instruction.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit_if imem_bus ();

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem_bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    always #5 clk = ~clk;

    int          checks;
    int          failures;
    int unsigned gnt_pct, ready_pct, redir_pct, lat_min, lat_max;
    logic        force_redirect;
    logic [31:0] force_pc;
    logic        pend_valid;
    int          pend_cnt;
    logic [31:0] pend_data;
    logic [31:0] salt;
    logic [31:0] exp_pc, exp_fetch;
    logic        expect_empty;
    logic        req_seen, granted, dead_seen;
    logic [31:0] req_addr_seen, grant_addr;
    int          grant_count, pop_count, pop_n;
    logic [31:0] pop_log [4];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, let the bus settle, then model the edge.
    task automatic step();
        logic pop;
        @(negedge clk);
        if (expect_empty) begin
            check_output("flush_empties_fifo", {31'd0, inst_valid}, 32'd0);
            expect_empty = 1'b0;
        end
        inst_ready  = ($urandom_range(99) < ready_pct);
        redirect    = 1'b0;
        redirect_pc = $urandom;
        if (force_redirect) begin
            redirect       = 1'b1;
            redirect_pc    = force_pc;
            force_redirect = 1'b0;
        end else if ($urandom_range(99) < redir_pct) begin
            redirect = 1'b1;
        end
        imem_bus.imem_rvalid = 1'b0;
        imem_bus.imem_rdata  = $urandom;
        if (pend_valid) begin
            if (pend_cnt == 0) begin
                imem_bus.imem_rvalid = 1'b1;
                imem_bus.imem_rdata  = pend_data;
                pend_valid           = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        imem_bus.imem_gnt = 1'b0;
        #1;
        req_seen      = imem_bus.imem_req;
        req_addr_seen = imem_bus.imem_addr;
        granted       = 1'b0;
        if (pend_valid) begin
            check_output("no_req_while_outstanding", {31'd0, req_seen}, 32'd0);
        end
        if (req_seen === 1'b1 && $urandom_range(99) < gnt_pct) begin
            imem_bus.imem_gnt = 1'b1;
            granted           = 1'b1;
            grant_addr        = req_addr_seen;
            grant_count++;
            check_output("grant_addr", req_addr_seen, exp_fetch);
            exp_fetch  = exp_fetch + 32'd4;
            pend_valid = 1'b1;
            pend_cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
            pend_data  = mem_word(req_addr_seen);
        end
        #1;
        pop = inst_valid & inst_ready;
        if (inst_valid === 1'b1 && inst_data === 32'h0000_DEAD) begin
            dead_seen = 1'b1;
        end
        if (pop) begin
            check_output("pop_pc", inst_pc, exp_pc);
            check_output("pop_data", inst_data, mem_word(exp_pc));
            if (pop_n < 4) begin
                pop_log[pop_n] = inst_pc;
            end
            pop_n++;
            pop_count++;
            exp_pc = exp_pc + 32'd4;
        end
        if (redirect) begin
            exp_pc       = redirect_pc & 32'hFFFF_FFFC;
            exp_fetch    = redirect_pc & 32'hFFFF_FFFC;
            expect_empty = 1'b1;
        end
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step();
        end
    endtask

    task automatic wait_grant(input string tag, input int max_steps);
        int n;
        n = 0;
        granted = 1'b0;
        do begin
            step();
            n++;
        end while (!granted && n < max_steps);
        check_output(tag, {31'd0, granted}, 32'd1);
    endtask

    // Reset is pulsed asynchronously with a stray response on the bus that must be ignored.
    task automatic apply_reset(input logic [31:0] new_salt);
        @(negedge clk);
        reset                = 1'b0;
        redirect             = 1'b0;
        inst_ready           = 1'b0;
        imem_bus.imem_gnt    = 1'b0;
        imem_bus.imem_rvalid = 1'b1;
        imem_bus.imem_rdata  = 32'hBAD0_BAD0;
        #1;
        check_output("rst_imem_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_output("rst_imem_addr", imem_bus.imem_addr, RESET_PC);
        check_output("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check_output("rst_inst_data", inst_data, 32'd0);
        check_output("rst_inst_pc", inst_pc, 32'd0);
        pend_valid   = 1'b0;
        expect_empty = 1'b0;
        @(posedge clk);
        @(negedge clk);
        imem_bus.imem_rvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        salt      = new_salt;
        exp_pc    = RESET_PC;
        exp_fetch = RESET_PC;
        pop_n     = 0;
        for (int i = 0; i < 4; i++) begin
            pop_log[i] = 32'hxxxx_xxxx;
        end
        reset = 1'b1;
        #1;
        check_output("req_low_before_first_edge", {31'd0, imem_bus.imem_req}, 32'd0);
        step();
        check_output("req_first_cycle_after_reset", {31'd0, req_seen}, 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        imem_bus.imem_gnt = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
        gnt_pct = 100; ready_pct = 100; redir_pct = 0; lat_min = 1; lat_max = 1;
        force_redirect = 1'b0; force_pc = '0;
        pend_valid = 1'b0; pend_cnt = 0; pend_data = '0; salt = '0;
        exp_pc = RESET_PC; exp_fetch = RESET_PC; expect_empty = 1'b0;
        req_seen = 1'b0; granted = 1'b0; dead_seen = 1'b0;
        req_addr_seen = '0; grant_addr = '0;
        grant_count = 0; pop_count = 0; pop_n = 0;

        // Streaming with a 1-cycle memory: data is addr/4, one instruction every two cycles.
        apply_reset(32'd0);
        run_steps(7);
        check_output("first_pop_pc", pop_log[0], 32'h0);
        check_output("second_pop_pc", pop_log[1], 32'h4);
        check_output("third_pop_pc", pop_log[2], 32'h8);
        pop_count = 0;
        run_steps(20);
        check_output("throughput_pops_in_20", pop_count, 32'd10);

        // Decode stalled: the FIFO fills after two grants and requests stop.
        ready_pct   = 0;
        grant_count = 0;
        apply_reset(32'd0);
        run_steps(9);
        check_output("grants_while_stalled", grant_count, 32'd2);
        check_output("req_low_when_full", {31'd0, req_seen}, 32'd0);
        ready_pct = 100;
        run_steps(4);
        check_output("stall_pop0_pc", pop_log[0], 32'h0);
        check_output("stall_pop1_pc", pop_log[1], 32'h4);

        // Redirect while waiting: the late 0xDEAD response must be discarded.
        lat_min = 3; lat_max = 3;
        wait_grant("grant_before_wait_redirect", 10);
        pend_data      = 32'h0000_DEAD;
        dead_seen      = 1'b0;
        force_redirect = 1'b1;
        force_pc       = 32'h0000_0040;
        run_steps(3);
        check_output("no_req_while_dropping", {31'd0, req_seen}, 32'd0);
        lat_min = 1; lat_max = 1;
        step();
        check_output("req_after_drop", {31'd0, req_seen}, 32'd1);
        check_output("addr_after_drop", req_addr_seen, 32'h0000_0040);
        run_steps(10);
        check_output("dead_never_decoded", {31'd0, dead_seen}, 32'd0);

        // Redirect coinciding with the response, unaligned target.
        ready_pct = 0;
        wait_grant("grant_before_rvalid_redirect", 10);
        force_redirect = 1'b1;
        force_pc       = 32'h0000_0043;
        step();
        step();
        check_output("req_after_rvalid_redirect", {31'd0, req_seen}, 32'd1);
        check_output("addr_after_rvalid_redirect", req_addr_seen, 32'h0000_0040);

        // Address wrap at the top of memory.
        ready_pct      = 100;
        force_redirect = 1'b1;
        force_pc       = 32'hFFFF_FFFC;
        step();
        wait_grant("grant_wrap_a", 10);
        check_output("wrap_addr_top", grant_addr, 32'hFFFF_FFFC);
        wait_grant("grant_wrap_b", 10);
        check_output("wrap_addr_zero", grant_addr, 32'h0000_0000);

        // Reset pulse with a request outstanding, then restart from RESET_PC.
        lat_min = 3; lat_max = 3;
        wait_grant("grant_before_reset", 10);
        apply_reset(32'hC0DE_0000);
        check_output("restart_addr", req_addr_seen, RESET_PC);

        // Randomised traffic: grant stalls, variable latency, decode backpressure, redirects.
        gnt_pct = 70; ready_pct = 60; redir_pct = 4; lat_min = 1; lat_max = 3;
        run_steps(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1);
    end

endmodule
